rfa: RTL and testbench
======================

// Module: rfa
// PURPOSE
// - Register-file write-port arbiter for the compute unit.
// - Eight functional-unit result queues compete for one VGPR/SGPR write port:
//   SIMD0-3 and SIMF0-3.
// - Each cycle at most one valid queue entry is granted, chosen round-robin.
// - The winner gets a serviced pulse, and a one-hot FU-select word steers the
//   register-file write mux.
// PARAMETERS
// - None. Requester count (8) and select width (16) are fixed.
// PORTS
// - clk                          in   1   rising-edge clock, the only clock
// - rst                          in   1   reset; synchronous, active-low (0 = reset)
// - simd0_queue_entry_valid      in   1   SIMD0 queue head holds a pending write
// - simd1_queue_entry_valid      in   1   SIMD1 pending write
// - simd2_queue_entry_valid      in   1   SIMD2 pending write
// - simd3_queue_entry_valid      in   1   SIMD3 pending write
// - simf0_queue_entry_valid      in   1   SIMF0 pending write
// - simf1_queue_entry_valid      in   1   SIMF1 pending write
// - simf2_queue_entry_valid      in   1   SIMF2 pending write
// - simf3_queue_entry_valid      in   1   SIMF3 pending write
// - simd0..3_queue_entry_serviced  out  1 each  grant to SIMD0..3; pop the queue head this cycle
// - simf0..3_queue_entry_serviced  out  1 each  grant to SIMF0..3
// - execvgprsgpr_select_fu       out  16  one-hot source select for the RF write mux
// BEHAVIOUR
// - Requester index: 0-3 = simd0-3, 4-7 = simf0-3.
// - State: one 3-bit priority pointer, ptr. It names the highest-priority index.
//   Priority descends from ptr, ptr+1, ... and wraps from 7 to 0.
// - Grant is combinational, zero latency. It goes to the first valid requester
//   searching from ptr upward with wrap-around.
//   - Exactly one serviced output is high when any valid is high; otherwise none.
//   - A serviced output is never high when its valid is low.
// - execvgprsgpr_select_fu:
//   - bit i (0..7) = serviced of requester i.
//   - bits [15:8] are reserved and always 0.
//   - All-zero when there is no grant.
// - ptr update at the clk edge:
//   - If a grant was made to index g: ptr <= (g+1) mod 8.
//   - If there was no grant: ptr holds.
// - Handshake: a valid must stay high until serviced. The requester samples
//   serviced at the clk edge and then advances its queue.
//   - A requester that stays valid is re-arbitrated in the next cycle against
//     updated priority.
//   - Dropping valid before grant simply withdraws the request.
// - Fairness: with N requesters continuously valid, each is granted exactly
//   once every N cycles.
// - Reset (rst=0 sampled at a clk edge): ptr <= 0.
//   - While rst=0, all serviced outputs and select_fu are forced to 0,
//     regardless of the valids.
//   - Reset mid-stream discards the rotation position: the first grant after
//     reset goes to the lowest-index valid requester.
// - Simultaneous events: all eight valid gives a single grant, to the ptr index.
// - No X on outputs once rst has been asserted for one clock edge.
// TESTING
// - Reset, then all 8 valid held for 10 cycles -> serviced rotates simd0,
//   simd1, simd2, simd3, simf0, simf1, simf2, simf3, simd0, simd1.
//   select_fu = 0x0001, 0x0002, 0x0004, ... 0x0080, 0x0001, 0x0002.
// - Mid-rotation, drop simd0/simd2/simf0/simf2 -> grants cycle only among
//   simd1, simd3, simf1, simf3 (0x0002, 0x0008, 0x0020, 0x0080 repeating),
//   starting from the next valid index at or after ptr.
// - All valids 0 for 2 cycles -> every serviced = 0, select_fu = 0x0000,
//   ptr unchanged. Then re-raise all valids -> the grant resumes at the held ptr.
// - Only simf3 valid continuously -> simf3 serviced every cycle,
//   select_fu = 0x0080. Then add simd0 -> grants alternate simd0 and simf3.
// - Hold rst=0 while all valids are high -> all outputs 0.
//   Release rst after grants had advanced ptr to 5 -> first grant is simd0 (0x0001).
// - Scoreboard every cycle:
//   - popcount(serviced) <= 1.
//   - serviced implies valid.
//   - select_fu[7:0] equals the serviced vector, and [15:8] = 0.
//   - No valid requester starves for more than 8 consecutive cycles.

Source files
------------

// File: rtl/rfa.sv
`default_nettype none
// ============================================================================
// Module      : rfa
// Description : Round-robin arbiter granting one of eight FU result queues
//               (SIMD0-3, SIMF0-3) the shared VGPR/SGPR write port.
// Revision    : 1.0 - initial release
// ============================================================================
module rfa (
  input  logic        clk,
  input  logic        rst,
  input  logic        simd0_queue_entry_valid,
  input  logic        simd1_queue_entry_valid,
  input  logic        simd2_queue_entry_valid,
  input  logic        simd3_queue_entry_valid,
  input  logic        simf0_queue_entry_valid,
  input  logic        simf1_queue_entry_valid,
  input  logic        simf2_queue_entry_valid,
  input  logic        simf3_queue_entry_valid,
  output logic        simd0_queue_entry_serviced,
  output logic        simd1_queue_entry_serviced,
  output logic        simd2_queue_entry_serviced,
  output logic        simd3_queue_entry_serviced,
  output logic        simf0_queue_entry_serviced,
  output logic        simf1_queue_entry_serviced,
  output logic        simf2_queue_entry_serviced,
  output logic        simf3_queue_entry_serviced,
  output logic [15:0] execvgprsgpr_select_fu
);

  logic [7:0] valid_vec;
  logic [7:0] grant_vec;
  logic [2:0] ptr;
  logic [2:0] grant_idx;
  logic       grant_any;

  assign valid_vec = {simf3_queue_entry_valid, simf2_queue_entry_valid,
                      simf1_queue_entry_valid, simf0_queue_entry_valid,
                      simd3_queue_entry_valid, simd2_queue_entry_valid,
                      simd1_queue_entry_valid, simd0_queue_entry_valid};

  // Search upward from ptr; 3-bit index arithmetic provides the 7->0 wrap.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr;
    for (int k = 0; k < 8; k++) begin
      if (!grant_any && valid_vec[ptr + 3'(k)]) begin
        grant_any = 1'b1;
        grant_idx = ptr + 3'(k);
      end
    end
  end

  always_comb begin
    grant_vec = 8'h00;
    if (rst && grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= 3'd0;
    end else if (grant_any) begin
      ptr <= grant_idx + 3'd1;
    end
  end

  assign simd0_queue_entry_serviced = grant_vec[0];
  assign simd1_queue_entry_serviced = grant_vec[1];
  assign simd2_queue_entry_serviced = grant_vec[2];
  assign simd3_queue_entry_serviced = grant_vec[3];
  assign simf0_queue_entry_serviced = grant_vec[4];
  assign simf1_queue_entry_serviced = grant_vec[5];
  assign simf2_queue_entry_serviced = grant_vec[6];
  assign simf3_queue_entry_serviced = grant_vec[7];
  assign execvgprsgpr_select_fu     = {8'h00, grant_vec};

endmodule
`default_nettype wire

// File: tb/tb_rfa.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfa
// Description : Scoreboard bench for rfa against a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rfa;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  v   = 8'h00;
  logic [7:0]  svc;
  logic [15:0] sel;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         model_ptr = 0;
  int         wait_cnt[8];

  always #5 clk = ~clk;

  rfa dut (
    .clk                        (clk),
    .rst                        (rst),
    .simd0_queue_entry_valid    (v[0]),
    .simd1_queue_entry_valid    (v[1]),
    .simd2_queue_entry_valid    (v[2]),
    .simd3_queue_entry_valid    (v[3]),
    .simf0_queue_entry_valid    (v[4]),
    .simf1_queue_entry_valid    (v[5]),
    .simf2_queue_entry_valid    (v[6]),
    .simf3_queue_entry_valid    (v[7]),
    .simd0_queue_entry_serviced (svc[0]),
    .simd1_queue_entry_serviced (svc[1]),
    .simd2_queue_entry_serviced (svc[2]),
    .simd3_queue_entry_serviced (svc[3]),
    .simf0_queue_entry_serviced (svc[4]),
    .simf1_queue_entry_serviced (svc[5]),
    .simf2_queue_entry_serviced (svc[6]),
    .simf3_queue_entry_serviced (svc[7]),
    .execvgprsgpr_select_fu     (sel)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%04h required=0x%04h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the reference model's expected grant.
  task automatic cycle(input logic r, input logic [7:0] vv);
    logic [7:0] e;
    bit         found;
    @(posedge clk);
    #2;
    rst = r;
    v   = vv;
    e   = 8'h00;
    if (!r) begin
      model_ptr = 0;
    end else begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (model_ptr + k) % 8;
        if (!found && vv[idx]) begin
          found     = 1;
          e[idx]    = 1'b1;
          model_ptr = (idx + 1) % 8;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare once per cycle, well away from the rising edge.
  initial begin
    logic [7:0] e;
    int         worst;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("serviced", {8'h00, svc}, {8'h00, e});
        check("select_fu", sel, {8'h00, e});
        check("select_hi_zero", {8'h00, sel[15:8]}, 16'h0000);
        check("onehot", ($countones(svc) <= 1) ? 16'd1 : 16'd0, 16'd1);
        check("svc_implies_valid", {8'h00, svc & ~v}, 16'h0000);
        worst = 0;
        for (int i = 0; i < 8; i++) begin
          if (rst && v[i] && !svc[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        check("starvation", (worst <= 8) ? 16'd1 : 16'd0, 16'd1);
      end
    end
  end

  initial begin
    logic [7:0] rv;
    int         mode;
    // Reset held with every request pending: outputs must stay quiet.
    cycle(1'b0, 8'hFF);
    cycle(1'b0, 8'hFF);
    // Full rotation plus wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'hFF);
    // Mid-rotation drop of the even requesters.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hAA);
    // Idle: ptr must hold, then resume from it.
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF);
    // Single requester, then two alternating.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h80);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h81);
    // Reset mid-stream after ptr reaches 5.
    cycle(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hFF);
    cycle(1'b0, 8'hFF);
    cycle(1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF);
    // Randomized traffic with occasional resets.
    rv = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rv = 8'($urandom);
        1:       rv = 8'($urandom) & 8'($urandom);
        2:       rv = 8'($urandom) | 8'($urandom);
        default: rv = rv ^ (8'h01 << $urandom_range(0, 7));
      endcase
      cycle(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, rv);
    end
    cycle(1'b1, 8'h00);
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
